mux8_1_bh: RTL and testbench

- Behavioural 8-to-1 multiplexer: selects one of eight input lanes by a 3-bit select and drives it combinationally on y.
- Also provides a registered copy of the selected lane and a one-hot select decode for downstream timing-closed consumers and debug.
- Leaf datapath block, used wherever a single lane of an 8-lane bus must be picked.

---
 rtl/mux8_1_bh_pkg.sv | 10 +
 rtl/mux8_1_bh_if.sv | 16 +
 rtl/mux8_1_bh.sv | 49 ++++
 tb/tb_mux8_1_bh.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mux8_1_bh_pkg.sv
// Shared constants and select decode for the 8-lane picker and its consumers.
// Pure declarations: no latency, no flow control.
package mux_pkg;
    localparam int N_IN  = 8;
    localparam int SEL_W = 3;

    function automatic logic [N_IN-1:0] onehot8(input logic [SEL_W-1:0] sel);
        return N_IN'(1) << sel;
    endfunction
endpackage

// File: rtl/mux8_1_bh_if.sv
// Lane bus, select and results of the 8-to-1 picker.
// Carries no state; master drives lanes and select, slave returns the picks.
interface mux8_1_bh_if
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
);
    logic [N_IN*DATA_W-1:0] i;
    logic [SEL_W-1:0]       s;
    logic [DATA_W-1:0]      y;
    logic [DATA_W-1:0]      y_q;
    logic [N_IN-1:0]        sel_oh;

    modport master (output i, s, input y, y_q, sel_oh);
    modport slave  (input i, s, output y, y_q, sel_oh);
endinterface

// File: rtl/mux8_1_bh.sv
// 8-to-1 lane picker with a one-hot select decode and a registered copy of the pick.
// Latency: y and sel_oh zero cycles, y_q one cycle; no backpressure, accepts every cycle.
module mux8_1_bh
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic         clk,
    input  logic         rst,
    mux8_1_bh_if.slave   bus
);

    logic [DATA_W-1:0] y_d;
    logic [DATA_W-1:0] y_q;
    logic              sel_known;

    // The default arm only fires on an X/Z select in simulation, poisoning both
    // outputs so a bad select is never hidden; synthesis treats it as don't-care.
    always_comb begin
        y_d       = '0;
        sel_known = 1'b1;
        case (bus.s)
            3'd0: y_d = bus.i[0*DATA_W +: DATA_W];
            3'd1: y_d = bus.i[1*DATA_W +: DATA_W];
            3'd2: y_d = bus.i[2*DATA_W +: DATA_W];
            3'd3: y_d = bus.i[3*DATA_W +: DATA_W];
            3'd4: y_d = bus.i[4*DATA_W +: DATA_W];
            3'd5: y_d = bus.i[5*DATA_W +: DATA_W];
            3'd6: y_d = bus.i[6*DATA_W +: DATA_W];
            3'd7: y_d = bus.i[7*DATA_W +: DATA_W];
            default: begin
                y_d       = 'x;
                sel_known = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.y      = y_d;
        bus.sel_oh = sel_known ? onehot8(bus.s) : 'x;
        bus.y_q    = y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) y_q <= '0;
        else     y_q <= y_d;
    end

endmodule

// File: tb/tb_mux8_1_bh.sv
// Directed bench for the 8-to-1 picker: narrow (1-bit) and wide (8-bit) lane instances.
module tb_mux8_1_bh;
    import mux_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux8_1_bh_if #(.DATA_W(1)) bus1 ();
    mux8_1_bh_if #(.DATA_W(8)) bus8 ();

    mux8_1_bh #(.DATA_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mux8_1_bh #(.DATA_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] lat_exp [8] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
    logic [7:0] wide_exp [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [2:0] sx;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus1.i = 8'h00;
        bus1.s = 3'd0;
        bus8.i = 64'h0;
        bus8.s = 3'd0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_yq1", 8'(bus1.y_q), 8'h00);
        chk("rst_yq8", bus8.y_q, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Walking one: y=1, sel_oh mirrors i
        for (int k = 0; k < 8; k++) begin
            bus1.i = 8'h01 << k;
            bus1.s = 3'(k);
            #1;
            chk("walk_y", 8'(bus1.y), 8'h01);
            chk("walk_oh", bus1.sel_oh, 8'h01 << k);
            #9;
        end

        // Mismatched select
        bus1.i = 8'b0000_0001; bus1.s = 3'b001; #1;
        chk("mis_a", 8'(bus1.y), 8'h00);
        bus1.i = 8'b1111_1110; bus1.s = 3'b000; #1;
        chk("mis_b", 8'(bus1.y), 8'h00);
        bus1.i = 8'b1111_1110; bus1.s = 3'b111; #1;
        chk("mis_c", 8'(bus1.y), 8'h01);

        // Non-selected lanes toggle, lane 5 held high
        bus1.s = 3'b101;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus1.i = 8'($urandom) | 8'h20;
            #1;
            chk("tog_y", 8'(bus1.y), 8'h01);
            @(posedge clk); #1;
            chk("tog_yq", 8'(bus1.y_q), 8'h01);
        end

        // Registered latency over 8'hA5
        bus1.i = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus1.s = 3'(k);
            @(posedge clk); #1;
            chk("lat_yq", 8'(bus1.y_q), lat_exp[k]);
        end

        // Synchronous reset while y=1
        @(negedge clk);
        bus1.s = 3'd0;
        @(posedge clk); #1;
        chk("pre_rst_yq", 8'(bus1.y_q), 8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_y_live", 8'(bus1.y), 8'h01);
        chk("rst_yq_hold", 8'(bus1.y_q), 8'h01);
        @(posedge clk); #1;
        chk("rst_yq_e1", 8'(bus1.y_q), 8'h00);
        chk("rst_y_e1", 8'(bus1.y), 8'h01);
        @(posedge clk); #1;
        chk("rst_yq_e2", 8'(bus1.y_q), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_yq", 8'(bus1.y_q), 8'h01);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("glitch_yq", 8'(bus1.y_q), 8'h01);

        // Wide lanes
        bus8.i = 64'h7766_5544_3322_1100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus8.s = 3'(k);
            #1;
            chk("wide_y", bus8.y, wide_exp[k]);
            chk("wide_oh", bus8.sel_oh, onehot8(3'(k)));
            @(posedge clk); #1;
            chk("wide_yq", bus8.y_q, wide_exp[k]);
        end

        // Unknown select poisons outputs where the simulator can represent X
        @(negedge clk);
        sx = 3'bx01;
        bus8.s = sx;
        #1;
        if ($isunknown(bus8.s)) begin
            chk("x_sel_y", bus8.y, 8'hxx);
            chk("x_sel_oh", bus8.sel_oh, 8'hxx);
        end else begin
            chk("x_sel_y", bus8.y, wide_exp[bus8.s]);
            chk("x_sel_oh", bus8.sel_oh, 8'h01 << bus8.s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
